// File: rtl/booth_mul_seq_if.sv
// Operand/result handshake bundle for the iterative Booth multiplier.
// The master drives operands and consumes products; the slave is the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, signed or unsigned per
// transaction, valid/ready on both operand and result sides.
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_mul_seq_if.slave bus
);
  localparam int D  = WIDTH / 2 + 1;   // Booth digits
  localparam int EW = WIDTH + 2;       // extended operand width
  localparam int HW = WIDTH + 4;       // accumulator head: room for 2*a_ext plus carry
  localparam int LW = 2 * D;           // bits shifted out over the whole run
  localparam int RW = HW + LW;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [EW-1:0]        a_q;
  logic [EW:0]          bq;          // extended b with the implicit 0 below the LSB
  logic signed [RW-1:0] acc;
  logic [2*WIDTH-1:0]   prod_q;

  logic [EW-1:0]        a_ext, b_ext;
  logic signed [HW-1:0] pa, addend, hsum;
  logic signed [RW-1:0] acc_nxt;
  logic                 accept, last;

  assign a_ext  = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext  = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (cnt == CW'(D - 1));

  // Digit select, add at the head, then shift the whole register right by 2 so the
  // retired low bits accumulate exactly in the tail.
  always_comb begin
    pa     = {{(HW-EW){a_q[EW-1]}}, a_q};
    addend = '0;
    unique case (bq[2:0])
      3'b001, 3'b010: addend = pa;
      3'b011:         addend = pa <<< 1;
      3'b100:         addend = -(pa <<< 1);
      3'b101, 3'b110: addend = -pa;
      default:        addend = '0;
    endcase
    hsum    = acc[RW-1 -: HW] + addend;
    acc_nxt = $signed({hsum, acc[LW-1:0]}) >>> 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.product   = prod_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      bq     <= '0;
      acc    <= '0;
      prod_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      a_q <= a_ext;
      bq  <= {b_ext, 1'b0};
      acc <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      bq  <= bq >> 2;
      acc <= acc_nxt;
      if (last) prod_q <= acc_nxt[2*WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomized checks of booth_mul_seq at WIDTH=16.
module tb_booth_mul_seq;
  localparam int W = 16;
  localparam int D = W / 2 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  booth_mul_seq_if #(.WIDTH(W)) bus ();
  booth_mul_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [31:0] ae, be;
    ae = s ? {{16{a[W-1]}}, a} : {16'h0, a};
    be = s ? {{16{b[W-1]}}, b} : {16'h0, b};
    return ae * be;
  endfunction

  // Accept edge, then count cycles until out_valid (bounded).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat);
    bus.a = a; bus.b = b; bus.signed_mode = s; bus.in_valid = 1'b1;
    while (!bus.in_ready) step();
    step();
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.signed_mode = ~s;  // in-flight op must ignore these
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [31:0] exp);
    int lat;
    issue(a, b, s, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(D));
    chk({tag, "_prod"}, 64'(bus.product), 64'(exp));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_handoff"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic rs;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("reset", {30'd0, bus.in_ready, bus.out_valid, bus.product}, {30'd0, 2'b10, 32'h0});
    rst_n = 1'b1;
    step();

    run("s_7fff_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001);
    run("s_8000_0006", 16'h8000, 16'h0006, 1'b1, 32'hFFFD0000);
    run("s_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    run("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run("u_8000_0006", 16'h8000, 16'h0006, 1'b0, 32'h00030000);
    run("u_0000_0010", 16'h0000, 16'h0010, 1'b0, 32'h00000000);
    run("s_fffd_0007", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);

    // Backpressure: result held 5 cycles while a new request waits on in_valid.
    issue(16'h1234, 16'h0010, 1'b0, lat);
    chk("bp_lat", 64'(lat), 64'(D));
    bus.a = 16'h0003; bus.b = 16'hFFFB; bus.signed_mode = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {29'd0, bus.out_valid, bus.in_ready, 1'b0, bus.product},
          {29'd0, 3'b100, 32'h00012340});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    step();
    bus.in_valid = 1'b0;
    chk("bp_accepted", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp2_lat", 64'(lat), 64'(D));
    chk("bp2_prod", 64'(bus.product), 64'h00000000FFFFFFF1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset in the middle of a transaction.
    bus.a = 16'h00FF; bus.b = 16'h00FF; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {29'd0, bus.out_valid, bus.in_ready, 1'b0, bus.product}, {29'd0, 3'b010, 32'h0});
    step();
    rst_n = 1'b1;
    chk("rst_idle", 64'(bus.in_ready), 64'd1);
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.out_valid) lat++;
    end
    chk("rst_no_stale", 64'(lat), 64'd0);

    // Random operands with random request and hand-off gaps.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
      issue(ra, rb, rs, lat);
      chk("rnd_lat", 64'(lat), 64'(D));
      repeat ($urandom_range(0, 3)) step();
      chk("rnd_prod", 64'(bus.product), 64'(ref_mul(ra, rb, rs)));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
